// File: rtl/uart_alu_sequencer.sv
// Pops a 3-byte frame (operand A, operand B, opcode) from the UART RX FIFO into
// registers that drive the ALU, then pushes the captured ALU result to the TX FIFO.
// Latency: 5 cycles per frame minimum (3 pops, 1 ALU settle cycle, 1 push cycle).
// Backpressure: RX pops only while the RX FIFO is non-empty. The sequencer holds in
// SEND while the TX FIFO is full. A partial frame is dropped after TIMEOUT_CYCLES
// idle cycles.
//
// Ports:
//   i_clk, i_reset_n          clock (rising edge), async active-low reset
//   i_rx_empty, i_rx_data     RX FIFO status and read data (data valid with o_rx_rd_en)
//   o_rx_rd_en                RX FIFO pop request (combinational)
//   o_alu_a/b/op              registered ALU operands and opcode
//   i_alu_result              combinational ALU result
//   i_tx_full                 TX FIFO full flag
//   o_tx_wr_en, o_tx_data     TX FIFO push pulse (combinational) and registered result byte
//   o_busy                    high whenever the sequencer is not waiting for operand A
//   o_timeout                 one-cycle pulse when a partial frame is discarded
//   o_frame_count             completed frames, wraps at 255
module uart_alu_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rx_empty,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  output logic                  o_rx_rd_en,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_full,
  output logic                  o_tx_wr_en,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic [7:0]            o_frame_count
);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_EXEC   = 3'd3,
    S_SEND   = 3'd4
  } state_t;

  // The counter only ever needs to hold TIMEOUT_CYCLES-1: the timeout fires on the
  // idle edge where it already holds that value, which is the TIMEOUT_CYCLES-th idle
  // cycle.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  state_t                r_state;
  logic [CW-1:0]         r_to_cnt;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_timeout;
  logic [7:0]            r_frame_count;

  logic w_collect;
  logic w_rx_pop;
  logic w_mid_frame_idle;
  logic w_to_fire;

  assign w_collect        = (r_state == S_GET_A) || (r_state == S_GET_B) || (r_state == S_GET_OP);
  assign w_rx_pop         = w_collect && !i_rx_empty;
  // Only a frame that has already started can time out; GET_A waits forever.
  assign w_mid_frame_idle = ((r_state == S_GET_B) || (r_state == S_GET_OP)) && i_rx_empty;
  // The pop has priority: w_mid_frame_idle is false whenever a byte is available.
  assign w_to_fire        = TO_EN && w_mid_frame_idle && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_GET_A;
      r_to_cnt      <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_tx_data     <= '0;
      r_timeout     <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_GET_A: begin
          r_to_cnt <= '0;
          if (w_rx_pop) begin
            r_alu_a <= i_rx_data;
            r_state <= S_GET_B;
          end
        end
        S_GET_B, S_GET_OP: begin
          if (w_rx_pop) begin
            r_to_cnt <= '0;
            if (r_state == S_GET_B) begin
              r_alu_b <= i_rx_data;
              r_state <= S_GET_OP;
            end else begin
              r_alu_op <= i_rx_data[OP_WIDTH-1:0];
              r_state  <= S_EXEC;
            end
          end else if (w_to_fire) begin
            // Partial operands are left as they are; the next frame overwrites them.
            r_to_cnt  <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_GET_A;
          end else if (TO_EN) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          // The ALU has had this whole cycle to settle on the registered operands.
          r_to_cnt  <= '0;
          r_tx_data <= i_alu_result;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          r_to_cnt <= '0;
          if (!i_tx_full) begin
            r_frame_count <= r_frame_count + 8'd1;
            r_state       <= S_GET_A;
          end
        end
        default: begin
          r_to_cnt <= '0;
          r_state  <= S_GET_A;
        end
      endcase
    end
  end

  assign o_rx_rd_en    = w_rx_pop;
  assign o_tx_wr_en    = (r_state == S_SEND) && !i_tx_full;
  assign o_busy        = (r_state != S_GET_A);
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_tx_data     = r_tx_data;
  assign o_timeout     = r_timeout;
  assign o_frame_count = r_frame_count;

endmodule
